// File: rtl/sn74ls153_dual_mux_if.sv
// Pin bundle for the dual 4-to-1 selector: shared selects, two strobed sections.
interface sn74ls153_dual_mux_if #(
    parameter int WIDTH = 1
);
    logic             A;
    logic             B;
    logic [WIDTH-1:0] C0;
    logic [WIDTH-1:0] C1;
    logic [WIDTH-1:0] C2;
    logic [WIDTH-1:0] C3;
    logic             G;
    logic [WIDTH-1:0] Y;
    logic [WIDTH-1:0] D0;
    logic [WIDTH-1:0] D1;
    logic [WIDTH-1:0] D2;
    logic [WIDTH-1:0] D3;
    logic             G2;
    logic [WIDTH-1:0] Y2;

    modport master (
        output A, B, C0, C1, C2, C3, G, D0, D1, D2, D3, G2,
        input  Y, Y2
    );

    modport slave (
        input  A, B, C0, C1, C2, C3, G, D0, D1, D2, D3, G2,
        output Y, Y2
    );
endinterface

// File: rtl/sn74ls153_dual_mux.sv
// 74LS153 dual 4-to-1 data selector; outputs optionally registered with
// one-cycle latency and synchronous active-low clear.
module sn74ls153_dual_mux #(
    parameter int WIDTH      = 1,
    parameter bit REGISTERED = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sn74ls153_dual_mux_if.slave   bus
);
    logic [1:0]       sel;
    logic [WIDTH-1:0] y_next;
    logic [WIDTH-1:0] y2_next;

    assign sel = {bus.B, bus.A};

    // Each bit lane is an independent 4:1 selector gated by its section strobe.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
            logic [3:0] c_bits;
            logic [3:0] d_bits;
            assign c_bits = {bus.C3[gi], bus.C2[gi], bus.C1[gi], bus.C0[gi]};
            assign d_bits = {bus.D3[gi], bus.D2[gi], bus.D1[gi], bus.D0[gi]};
            assign y_next[gi]  = ~bus.G  & c_bits[sel];
            assign y2_next[gi] = ~bus.G2 & d_bits[sel];
        end
    endgenerate

    generate
        if (REGISTERED) begin : g_reg
            logic [WIDTH-1:0] y_reg;
            logic [WIDTH-1:0] y2_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    y_reg  <= '0;
                    y2_reg <= '0;
                end else begin
                    y_reg  <= y_next;
                    y2_reg <= y2_next;
                end
            end

            assign bus.Y  = y_reg;
            assign bus.Y2 = y2_reg;
        end else begin : g_comb
            // Clock and reset have no role in the combinational variant.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign bus.Y  = y_next;
            assign bus.Y2 = y2_next;
        end
    endgenerate
endmodule

// File: tb/tb_sn74ls153_dual_mux.sv
// Scoreboard bench: registered WIDTH=1 instance and combinational WIDTH=4 instance.
module tb_sn74ls153_dual_mux;
    typedef struct {
        logic [3:0] y;
        logic [3:0] y2;
        string      name;
    } exp_t;

    logic clk;
    logic rst_n;
    int   applied;
    int   miscompares;
    exp_t q_reg[$];
    exp_t q_comb[$];
    event comb_ev;

    sn74ls153_dual_mux_if #(.WIDTH(1)) bus_r ();
    sn74ls153_dual_mux_if #(.WIDTH(4)) bus_c ();

    sn74ls153_dual_mux #(.WIDTH(1), .REGISTERED(1'b1)) dut_r (
        .clk(clk), .rst_n(rst_n), .bus(bus_r.slave)
    );
    sn74ls153_dual_mux #(.WIDTH(4), .REGISTERED(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(bus_c.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    // Registered monitor: every rising edge retires the vector driven before it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_reg.size() != 0) begin
                e = q_reg.pop_front();
                applied++;
                if (bus_r.Y !== e.y[0] || bus_r.Y2 !== e.y2[0]) begin
                    miscompares++;
                    $display("FAIL %s: Y=%b Y2=%b required Y=%b Y2=%b",
                             e.name, bus_r.Y, bus_r.Y2, e.y[0], e.y2[0]);
                end else
                    $display("ok   %s: Y=%b Y2=%b", e.name, bus_r.Y, bus_r.Y2);
            end
        end
    end

    // Combinational monitor: checks as soon as the driver signals new inputs.
    initial begin
        exp_t e;
        forever begin
            @(comb_ev);
            #1;
            if (q_comb.size() != 0) begin
                e = q_comb.pop_front();
                applied++;
                if (bus_c.Y !== e.y || bus_c.Y2 !== e.y2) begin
                    miscompares++;
                    $display("FAIL %s: Y=%h Y2=%h required Y=%h Y2=%h",
                             e.name, bus_c.Y, bus_c.Y2, e.y, e.y2);
                end else
                    $display("ok   %s: Y=%h Y2=%h", e.name, bus_c.Y, bus_c.Y2);
            end
        end
    end

    task automatic drive_reg(input logic rst, input logic b, input logic a,
                             input logic [3:0] c, input logic g,
                             input logic [3:0] d, input logic g2,
                             input logic ey, input logic ey2, input string nm);
        exp_t e;
        @(negedge clk);
        rst_n    = rst;
        bus_r.B  = b;     bus_r.A  = a;
        bus_r.C0 = c[0];  bus_r.C1 = c[1];  bus_r.C2 = c[2];  bus_r.C3 = c[3];
        bus_r.D0 = d[0];  bus_r.D1 = d[1];  bus_r.D2 = d[2];  bus_r.D3 = d[3];
        bus_r.G  = g;     bus_r.G2 = g2;
        e.y    = {3'b000, ey};
        e.y2   = {3'b000, ey2};
        e.name = nm;
        q_reg.push_back(e);
    endtask

    task automatic drive_comb(input logic b, input logic a,
                              input logic [3:0] c0, input logic [3:0] c1,
                              input logic [3:0] c2, input logic [3:0] c3,
                              input logic g,
                              input logic [3:0] d0, input logic [3:0] d1,
                              input logic [3:0] d2, input logic [3:0] d3,
                              input logic g2,
                              input logic [3:0] ey, input logic [3:0] ey2,
                              input string nm);
        exp_t e;
        bus_c.B  = b;   bus_c.A  = a;
        bus_c.C0 = c0;  bus_c.C1 = c1;  bus_c.C2 = c2;  bus_c.C3 = c3;
        bus_c.D0 = d0;  bus_c.D1 = d1;  bus_c.D2 = d2;  bus_c.D3 = d3;
        bus_c.G  = g;   bus_c.G2 = g2;
        e.y    = ey;
        e.y2   = ey2;
        e.name = nm;
        q_comb.push_back(e);
        -> comb_ev;
        #5;
    endtask

    initial begin
        applied     = 0;
        miscompares = 0;
        rst_n       = 1'b0;

        //         rst  B  A  C3..C0  G   D3..D0  G2   Y  Y2
        drive_reg(1'b0, 1, 1, 4'b1111, 1, 4'b1111, 1, 0, 0, "reset_edge1");
        drive_reg(1'b0, 1, 1, 4'b1111, 1, 4'b1111, 1, 0, 0, "reset_edge2");
        drive_reg(1'b1, 0, 0, 4'b0001, 0, 4'b0000, 1, 1, 0, "release_c0");
        drive_reg(1'b1, 0, 0, 4'b0110, 0, 4'b0000, 1, 0, 0, "sweep_00");
        drive_reg(1'b1, 0, 1, 4'b0110, 0, 4'b0000, 1, 1, 0, "sweep_01");
        drive_reg(1'b1, 1, 0, 4'b0110, 0, 4'b0000, 1, 1, 0, "sweep_10");
        drive_reg(1'b1, 1, 1, 4'b0110, 0, 4'b0000, 1, 0, 0, "sweep_11");
        drive_reg(1'b1, 1, 1, 4'b1000, 1, 4'b0000, 1, 0, 0, "strobe_high");
        drive_reg(1'b1, 0, 0, 4'b0001, 0, 4'b0000, 1, 1, 0, "strobe_low_c0");
        drive_reg(1'b1, 1, 1, 4'b0001, 0, 4'b0000, 1, 0, 0, "strobe_low_c3");
        drive_reg(1'b1, 0, 0, 4'b0001, 0, 4'b1111, 1, 1, 0, "indep_g_on");
        drive_reg(1'b1, 0, 0, 4'b0001, 1, 4'b1111, 0, 0, 1, "indep_g2_on");
        drive_reg(1'b1, 1, 0, 4'b1111, 1, 4'b0100, 0, 0, 1, "sec2_sel_10");
        drive_reg(1'b1, 0, 1, 4'b1111, 1, 4'b0100, 0, 0, 0, "sec2_sel_01");
        drive_reg(1'b1, 0, 0, 4'b0001, 0, 4'b0001, 0, 1, 1, "steady_both");
        drive_reg(1'b0, 0, 0, 4'b0001, 0, 4'b0001, 0, 0, 0, "midstream_reset");
        drive_reg(1'b1, 0, 0, 4'b0001, 0, 4'b0001, 0, 1, 1, "after_release");

        // Combinational WIDTH=4 instance: reset held low to show it is ignored.
        @(negedge clk);
        rst_n = 1'b0;
        drive_comb(1, 0, 4'hA, 4'h5, 4'hF, 4'h0, 0,
                   4'h1, 4'h2, 4'h3, 4'h4, 1, 4'hF, 4'h0, "comb_sel10");
        drive_comb(1, 0, 4'hA, 4'h5, 4'hF, 4'h0, 1,
                   4'h1, 4'h2, 4'h3, 4'h4, 1, 4'h0, 4'h0, "comb_strobe");
        drive_comb(0, 1, 4'hA, 4'h5, 4'hF, 4'h0, 0,
                   4'h1, 4'h2, 4'h3, 4'h4, 0, 4'h5, 4'h2, "comb_sel01");
        drive_comb(1, 1, 4'hA, 4'h5, 4'hF, 4'h0, 1,
                   4'h1, 4'h2, 4'h3, 4'h4, 0, 4'h0, 4'h4, "comb_sel11");
        drive_comb(0, 0, 4'hA, 4'h5, 4'hF, 4'h0, 0,
                   4'h1, 4'h2, 4'h3, 4'h4, 0, 4'hA, 4'h1, "comb_sel00");

        repeat (3) @(posedge clk);
        #2;
        if (q_reg.size() != 0 || q_comb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: pending expectations reg=%0d comb=%0d required 0",
                     q_reg.size(), q_comb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
